// File: rtl/divider_controller.sv
// Control sequencer for a restoring shift/subtract divider: load, one quotient bit per clock, done pulse.
// Optional divide-by-zero short-circuit is enabled with `define DIV_BY_ZERO_DETECT_EN.
module divider_controller #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             rem_neg,
`ifdef DIV_BY_ZERO_DETECT_EN
    input  logic             divisor_zero,
    output logic             dbz,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_load,
    output logic             rem_load,
    output logic             rem_shift,
    output logic             rem_write,
    output logic             quo_shift,
    output logic             quo_bit,
    output logic [CNT_W-1:0] iter_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ITER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_next = '0;
`ifdef DIV_BY_ZERO_DETECT_EN
                state_next = divisor_zero ? ST_DONE : ST_ITER;
`else
                state_next = ST_ITER;
`endif
            end
            ST_ITER: begin
                // Counter saturates on the final iteration so DONE reports WIDTH-1.
                if (cnt_reg == LAST_ITER) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
        // Abort overrides every other transition once an operation is under way.
        if (abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

`ifdef DIV_BY_ZERO_DETECT_EN
    logic dbz_reg;
    logic dbz_next;

    // Set only on the LOAD -> DONE shortcut, so it lives exactly for the DONE cycle.
    assign dbz_next = (state_reg == ST_LOAD) && divisor_zero && !abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbz_reg <= 1'b0;
        end else begin
            dbz_reg <= dbz_next;
        end
    end

    assign dbz = dbz_reg && (state_reg == ST_DONE);
`endif

    logic in_load;
    logic in_iter;

    assign in_load   = (state_reg == ST_LOAD);
    assign in_iter   = (state_reg == ST_ITER);

    assign busy      = in_load || in_iter;
    assign done      = (state_reg == ST_DONE);
    assign div_load  = in_load;
    assign rem_load  = in_load;
    assign rem_shift = in_iter;
    assign quo_shift = in_iter;
    assign quo_bit   = in_iter && !rem_neg;
    assign rem_write = in_iter && !rem_neg;
    assign iter_cnt  = cnt_reg;

endmodule
